lsu: RTL and testbench
======================

Name: lsu

Overview:
Load/store unit on the consumer side of the ALU result path. It takes the ALU-computed effective address (ALU_Result) plus Rs2 store data, issues one word-aligned request to data memory over a req/gnt/rvalid handshake, and returns sign- or zero-extended load data for writeback. While an access is outstanding it stalls the pipeline.

Parameters:
XLEN, 32, data and address width; the block is defined for 32 only.

Ports:
clk  in  1  core clock, rising edge
rst_n  in  1  asynchronous active-low reset
valid_i  in  1  memory instruction presented this cycle
is_load  in  1  instruction is a load
is_store  in  1  instruction is a store
funct3  in  3  000 B, 001 H, 010 W, 100 BU (load only), 101 HU (load only)
addr_i  in  XLEN  effective address (ALU_Result)
wdata_i  in  XLEN  store data (Rs2)
stall_o  out  1  access outstanding; pipeline must hold
done_o  out  1  one-cycle pulse when an access completes
rd_data_o  out  XLEN  extended load data; valid when done_o=1 for a load
err_o  out  1  one-cycle pulse: misaligned or illegal request
mem_req_o  out  1  memory request
mem_we_o  out  1  1=write, 0=read
mem_addr_o  out  XLEN  word address {addr_i[31:2],2'b00}
mem_wdata_o  out  XLEN  lane-replicated store data
mem_be_o  out  4  byte enables
mem_gnt_i  in  1  memory accepts the request this cycle
mem_rvalid_i  in  1  read data valid
mem_rdata_i  in  XLEN  read data word

Behaviour:
- Reset (asynchronous, rst_n=0): state=IDLE. All registered outputs go to 0: mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o, rd_data_o, done_o, err_o. stall_o=0.
- FSM states: IDLE, REQ, WAIT_R. stall_o = (state != IDLE), combinational.
- IDLE, when valid_i=1 and exactly one of is_load/is_store is set:
  - Illegal if funct3 is not in the encoding list, or if it is BU/HU with is_store.
  - Misaligned if H/HU with addr_i[0]=1, or W with addr_i[1:0]!=0.
  - Illegal or misaligned: err_o pulses next cycle, no memory access, stay IDLE.
  - Otherwise: latch addr[1:0], funct3, and is_load; drive memory outputs next cycle with mem_req_o=1; go to REQ.
- IDLE, when valid_i=1 and both is_load and is_store are set: err_o pulse, no access.
- IDLE, when valid_i=1 and neither is set: ignored.
- REQ: mem_req_o and all mem_* outputs stay stable until mem_gnt_i=1. On gnt, mem_req_o drops next cycle.
  - Store: done_o pulses next cycle; go to IDLE.
  - Load: go to WAIT_R.
- WAIT_R: wait for mem_rvalid_i. On rvalid, rd_data_o and done_o are registered next cycle; go to IDLE. rvalid is never expected in the same cycle as gnt.
- Ignored inputs:
  - valid_i is ignored outside IDLE; the pipeline holds the instruction via stall_o.
  - mem_gnt_i is ignored unless in REQ.
  - mem_rvalid_i is ignored unless in WAIT_R. This includes stale responses after a mid-access reset.
- Store lanes:
  - SB: be = 4'b0001 << a[1:0]; wdata = {4{wdata_i[7:0]}}.
  - SH: be = a[1] ? 4'b1100 : 4'b0011; wdata = {2{wdata_i[15:0]}}.
  - SW: be = 4'b1111; wdata = wdata_i.
  - Loads drive be=4'b1111 and mem_we_o=0.
- Load extraction uses the latched a[1:0]:
  - B: byte = rdata[8*a+7 : 8*a], sign-extended.
  - BU: same byte, zero-extended.
  - H/HU: half = rdata[16*a[1]+15 : 16*a[1]], sign- or zero-extended.
  - W: full word.
- rd_data_o holds its value between loads. Stores do not modify it.
- Latency with an instruction accepted at edge T:
  - mem_req_o is high from T+1.
  - Zero-wait memory gives gnt at T+1 and rvalid at T+2; load done_o at T+3.
  - Zero-wait store done_o at T+2.
  - Each cycle of gnt or rvalid delay adds one cycle.
- done_o and err_o never assert in the same cycle.
- Reset asserted in REQ or WAIT_R aborts the access: no done_o, outputs cleared immediately.

Test Plan:
- LW addr=0x100, rdata=0xDEADBEEF, gnt and rvalid zero-wait -> mem_addr_o=0x100, be=1111, we=0; done_o at T+3 with rd_data_o=0xDEADBEEF; stall_o high T+1..T+2.
- LB addr=0x103 with rdata=0x80FF_0000 -> rd_data_o=0xFFFFFF80. LBU at the same address -> 0x00000080. LHU addr=0x102 -> 0x000080FF.
- SB addr=0x201, wdata_i=0x12345678 -> mem_addr_o=0x200, be=0010, mem_wdata_o=0x78787878, we=1; gnt withheld 3 cycles -> mem_* outputs stable throughout; done_o exactly 1 cycle after gnt.
- LW addr=0x102, and SH addr=0x101 -> err_o pulse, mem_req_o stays 0, stall_o stays 0. is_load=is_store=1 -> err_o. Store with funct3=100 -> err_o.
- Load in WAIT_R, rst_n pulsed low, then mem_rvalid_i=1 in IDLE -> all outputs 0, no done_o, rd_data_o stays 0.
- Back-to-back SW then LW, with valid_i held high while stall_o=1 -> second access issues only after the first done_o; exactly two requests seen on the memory side.

Source files
------------

// File: rtl/lsu.sv
// Load/store unit: issues one word-aligned data-memory access per instruction over a
// req/gnt/rvalid handshake and returns extended load data, stalling the pipeline meanwhile.
module lsu #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            valid_i,
    input  logic            is_load,
    input  logic            is_store,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] addr_i,
    input  logic [XLEN-1:0] wdata_i,
    output logic            stall_o,
    output logic            done_o,
    output logic [XLEN-1:0] rd_data_o,
    output logic            err_o,
    output logic            mem_req_o,
    output logic            mem_we_o,
    output logic [XLEN-1:0] mem_addr_o,
    output logic [XLEN-1:0] mem_wdata_o,
    output logic [3:0]      mem_be_o,
    input  logic            mem_gnt_i,
    input  logic            mem_rvalid_i,
    input  logic [XLEN-1:0] mem_rdata_i
);

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        WAIT_R = 2'd2
    } state_t;

    state_t          state, state_d;
    logic            req_d, we_d, done_d, err_d, lat_load, lat_load_d;
    logic [XLEN-1:0] addr_d, wdata_d, rd_data_d;
    logic [3:0]      be_d;
    logic [1:0]      lat_off, lat_off_d;
    logic [2:0]      lat_f3, lat_f3_d;

    logic            illegal_c, misaligned_c;
    logic [XLEN-1:0] byte_sh_c, half_sh_c;

    assign stall_o = (state != IDLE);

    // Decode checks for the instruction presented in IDLE
    always_comb begin
        illegal_c    = 1'b0;
        misaligned_c = 1'b0;
        case (funct3)
            F3_B:         illegal_c = 1'b0;
            F3_H:         misaligned_c = addr_i[0];
            F3_W:         misaligned_c = (addr_i[1:0] != 2'b00);
            F3_BU:        illegal_c = is_store;
            F3_HU: begin
                illegal_c    = is_store;
                misaligned_c = addr_i[0];
            end
            default:      illegal_c = 1'b1;
        endcase
    end

    assign byte_sh_c = mem_rdata_i >> {lat_off, 3'b000};
    assign half_sh_c = mem_rdata_i >> {lat_off[1], 4'b0000};

    // Next-state and next-output logic
    always_comb begin
        state_d    = state;
        req_d      = mem_req_o;
        we_d       = mem_we_o;
        addr_d     = mem_addr_o;
        wdata_d    = mem_wdata_o;
        be_d       = mem_be_o;
        rd_data_d  = rd_data_o;
        done_d     = 1'b0;
        err_d      = 1'b0;
        lat_off_d  = lat_off;
        lat_f3_d   = lat_f3;
        lat_load_d = lat_load;

        case (state)
            IDLE: begin
                if (valid_i && is_load && is_store) begin
                    err_d = 1'b1;
                end else if (valid_i && (is_load || is_store)) begin
                    if (illegal_c || misaligned_c) begin
                        err_d = 1'b1;
                    end else begin
                        state_d    = REQ;
                        req_d      = 1'b1;
                        we_d       = is_store;
                        addr_d     = {addr_i[XLEN-1:2], 2'b00};
                        lat_off_d  = addr_i[1:0];
                        lat_f3_d   = funct3;
                        lat_load_d = is_load;
                        if (is_load) begin
                            be_d    = 4'b1111;
                            wdata_d = '0;
                        end else begin
                            case (funct3)
                                F3_B: begin
                                    be_d    = 4'(4'b0001 << addr_i[1:0]);
                                    wdata_d = {4{wdata_i[7:0]}};
                                end
                                F3_H: begin
                                    be_d    = addr_i[1] ? 4'b1100 : 4'b0011;
                                    wdata_d = {2{wdata_i[15:0]}};
                                end
                                default: begin
                                    be_d    = 4'b1111;
                                    wdata_d = wdata_i;
                                end
                            endcase
                        end
                    end
                end
            end
            REQ: begin
                if (mem_gnt_i) begin
                    req_d = 1'b0;
                    if (lat_load) begin
                        state_d = WAIT_R;
                    end else begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            WAIT_R: begin
                if (mem_rvalid_i) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    case (lat_f3)
                        F3_B:    rd_data_d = {{24{byte_sh_c[7]}}, byte_sh_c[7:0]};
                        F3_BU:   rd_data_d = {24'b0, byte_sh_c[7:0]};
                        F3_H:    rd_data_d = {{16{half_sh_c[15]}}, half_sh_c[15:0]};
                        F3_HU:   rd_data_d = {16'b0, half_sh_c[15:0]};
                        default: rd_data_d = mem_rdata_i;
                    endcase
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            mem_be_o    <= 4'b0000;
            rd_data_o   <= '0;
            done_o      <= 1'b0;
            err_o       <= 1'b0;
            lat_off     <= 2'b00;
            lat_f3      <= 3'b000;
            lat_load    <= 1'b0;
        end else begin
            state       <= state_d;
            mem_req_o   <= req_d;
            mem_we_o    <= we_d;
            mem_addr_o  <= addr_d;
            mem_wdata_o <= wdata_d;
            mem_be_o    <= be_d;
            rd_data_o   <= rd_data_d;
            done_o      <= done_d;
            err_o       <= err_d;
            lat_off     <= lat_off_d;
            lat_f3      <= lat_f3_d;
            lat_load    <= lat_load_d;
        end
    end

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: directed cases plus randomized accesses against a
// byte-lane reference model.
module tb_lsu;

    logic        clk, rst_n;
    logic        valid_i, is_load, is_store;
    logic [2:0]  funct3;
    logic [31:0] addr_i, wdata_i;
    logic        stall_o, done_o, err_o;
    logic [31:0] rd_data_o;
    logic        mem_req_o, mem_we_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic [3:0]  mem_be_o;
    logic        mem_gnt_i, mem_rvalid_i;
    logic [31:0] mem_rdata_i;

    int tests = 0;
    int fails = 0;
    logic [31:0] exp_rd = 32'h0;

    lsu #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .is_load(is_load),
        .is_store(is_store), .funct3(funct3), .addr_i(addr_i), .wdata_i(wdata_i),
        .stall_o(stall_o), .done_o(done_o), .rd_data_o(rd_data_o), .err_o(err_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o), .mem_gnt_i(mem_gnt_i),
        .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: access size/sign from funct3, then per-byte lanes and shifts
    task automatic model(input bit ld, input bit st, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                         output bit err, output logic [3:0] be,
                         output logic [31:0] wdx, output logic [31:0] ldv);
        int size;
        int off;
        bit sgn;
        bit legal;
        logic [31:0] v;
        logic [31:0] mask;
        size = 1; sgn = 1'b0; legal = 1'b1;
        off = int'(a % 4);
        case (f3)
            3'd0: begin size = 1; sgn = 1'b1; end
            3'd1: begin size = 2; sgn = 1'b1; end
            3'd2: begin size = 4; end
            3'd4: begin size = 1; legal = ld; end
            3'd5: begin size = 2; legal = ld; end
            default: legal = 1'b0;
        endcase
        err = (ld && st) || !legal || (a % size != 0);
        be = 4'h0;
        wdx = 32'h0;
        for (int b = 0; b < 4; b++) begin
            be[b] = ld ? 1'b1 : (b >= off && b < off + size);
            wdx[8*b +: 8] = wd[8*(b % size) +: 8];
        end
        v = rd >> (8 * off);
        if (size == 4) ldv = rd;
        else begin
            mask = (32'h1 << (8 * size)) - 32'h1;
            ldv = v & mask;
            if (sgn && v[8*size-1]) ldv = ldv | ~mask;
        end
    endtask

    // Drive one instruction and follow it cycle by cycle to completion
    task automatic access(input bit ld, input bit st, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                          input int gd, input int rvd);
        bit err;
        logic [3:0] be;
        logic [31:0] wdx, ldv;
        model(ld, st, f3, a, wd, rd, err, be, wdx, ldv);
        @(negedge clk);
        valid_i = 1'b1; is_load = ld; is_store = st; funct3 = f3; addr_i = a; wdata_i = wd;
        @(negedge clk);
        valid_i = 1'b0;
        if (!ld && !st) begin
            check("ignored_err", 32'(err_o), 32'h0);
            check("ignored_req", 32'(mem_req_o), 32'h0);
        end else if (err) begin
            check("err_pulse", 32'(err_o), 32'h1);
            check("err_noreq", 32'(mem_req_o), 32'h0);
            check("err_nostall", 32'(stall_o), 32'h0);
            check("err_nodone", 32'(done_o), 32'h0);
            @(negedge clk);
            check("err_oneshot", 32'(err_o), 32'h0);
        end else begin
            check("req", 32'(mem_req_o), 32'h1);
            check("stall", 32'(stall_o), 32'h1);
            check("we", 32'(mem_we_o), 32'(st));
            check("addr", mem_addr_o, a & 32'hFFFF_FFFC);
            check("be", 32'(mem_be_o), 32'(be));
            if (st) check("wdata", mem_wdata_o, wdx);
            for (int i = 0; i < gd; i++) begin
                @(negedge clk);
                check("hold_req", 32'(mem_req_o), 32'h1);
                check("hold_addr", mem_addr_o, a & 32'hFFFF_FFFC);
                check("hold_be", 32'(mem_be_o), 32'(be));
                if (st) check("hold_wdata", mem_wdata_o, wdx);
                check("hold_nodone", 32'(done_o), 32'h0);
            end
            mem_gnt_i = 1'b1;
            @(negedge clk);
            mem_gnt_i = 1'b0;
            check("req_drop", 32'(mem_req_o), 32'h0);
            if (st) begin
                check("st_done", 32'(done_o), 32'h1);
                check("st_noerr", 32'(err_o), 32'h0);
                check("st_stall_off", 32'(stall_o), 32'h0);
                check("st_rd_kept", rd_data_o, exp_rd);
            end else begin
                check("ld_wait_nodone", 32'(done_o), 32'h0);
                check("ld_wait_stall", 32'(stall_o), 32'h1);
                for (int i = 0; i < rvd; i++) begin
                    @(negedge clk);
                    check("rv_wait_nodone", 32'(done_o), 32'h0);
                end
                mem_rvalid_i = 1'b1; mem_rdata_i = rd;
                @(negedge clk);
                mem_rvalid_i = 1'b0;
                exp_rd = ldv;
                check("ld_done", 32'(done_o), 32'h1);
                check("ld_data", rd_data_o, exp_rd);
                check("ld_stall_off", 32'(stall_o), 32'h0);
            end
            @(negedge clk);
            check("done_oneshot", 32'(done_o), 32'h0);
        end
    endtask

    int ngnt, ndone;
    bit rv_pend;
    logic we_first, we_second;

    initial begin
        rst_n = 1'b0; valid_i = 1'b0; is_load = 1'b0; is_store = 1'b0; funct3 = 3'b0;
        addr_i = 32'h0; wdata_i = 32'h0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = 32'h0;
        repeat (2) @(negedge clk);
        check("rst_req", 32'(mem_req_o), 32'h0);
        check("rst_stall", 32'(stall_o), 32'h0);
        check("rst_rd", rd_data_o, 32'h0);
        check("rst_addr", mem_addr_o, 32'h0);
        check("rst_be", 32'(mem_be_o), 32'h0);
        rst_n = 1'b1;

        access(1, 0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0, 0);
        access(1, 0, 3'b000, 32'h103, 32'h0, 32'h80FF_0000, 0, 1);
        access(1, 0, 3'b100, 32'h103, 32'h0, 32'h80FF_0000, 1, 0);
        access(1, 0, 3'b101, 32'h102, 32'h0, 32'h80FF_0000, 0, 0);
        access(0, 1, 3'b000, 32'h201, 32'h12345678, 32'h0, 3, 0);
        access(1, 0, 3'b010, 32'h102, 32'h0, 32'h0, 0, 0);
        access(0, 1, 3'b001, 32'h101, 32'h1234, 32'h0, 0, 0);
        access(1, 1, 3'b010, 32'h100, 32'h0, 32'h0, 0, 0);
        access(0, 1, 3'b100, 32'h100, 32'h0, 32'h0, 0, 0);

        // Abort a load in WAIT_R with reset, then offer a stale response
        @(negedge clk);
        valid_i = 1'b1; is_load = 1'b1; is_store = 1'b0; funct3 = 3'b010; addr_i = 32'h100;
        @(negedge clk);
        valid_i = 1'b0; mem_gnt_i = 1'b1;
        @(negedge clk);
        mem_gnt_i = 1'b0;
        check("abort_in_wait", 32'(stall_o), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        check("abort_stall", 32'(stall_o), 32'h0);
        check("abort_req", 32'(mem_req_o), 32'h0);
        check("abort_addr", mem_addr_o, 32'h0);
        check("abort_rd", rd_data_o, 32'h0);
        @(negedge clk);
        rst_n = 1'b1; exp_rd = 32'h0;
        mem_rvalid_i = 1'b1; mem_rdata_i = 32'hFFFF_FFFF;
        @(negedge clk);
        mem_rvalid_i = 1'b0;
        check("stale_nodone", 32'(done_o), 32'h0);
        check("stale_rd", rd_data_o, 32'h0);
        check("stale_stall", 32'(stall_o), 32'h0);

        // SW then LW with valid held high through the stall
        valid_i = 1'b1; is_store = 1'b1; is_load = 1'b0; funct3 = 3'b010;
        addr_i = 32'h300; wdata_i = 32'hCAFEF00D; mem_rdata_i = 32'h11223344;
        ngnt = 0; ndone = 0; rv_pend = 1'b0; we_first = 1'bx; we_second = 1'bx;
        for (int cyc = 0; cyc < 30 && ndone < 2; cyc++) begin
            @(negedge clk);
            mem_gnt_i = 1'b0;
            mem_rvalid_i = rv_pend;
            rv_pend = 1'b0;
            if (done_o) begin
                ndone++;
                if (ndone == 1) begin is_load = 1'b1; is_store = 1'b0; addr_i = 32'h304; end
                else valid_i = 1'b0;
            end
            if (mem_req_o) begin
                mem_gnt_i = 1'b1;
                ngnt++;
                if (ngnt == 1) we_first = mem_we_o; else we_second = mem_we_o;
                if (!mem_we_o) rv_pend = 1'b1;
                check("b2b_done_before_2nd", 32'(ngnt == 2 ? ndone : 1), 32'h1);
            end
        end
        valid_i = 1'b0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
        check("b2b_grants", 32'(ngnt), 32'd2);
        check("b2b_dones", 32'(ndone), 32'd2);
        check("b2b_first_we", 32'(we_first), 32'h1);
        check("b2b_second_we", 32'(we_second), 32'h0);
        check("b2b_rd", rd_data_o, 32'h11223344);
        exp_rd = 32'h11223344;

        for (int n = 0; n < 60; n++) begin
            access(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                   $urandom, $urandom, $urandom, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
